// File: rtl/fdivsqrt_seq_ctrl.sv
// rtl/fdivsqrt_seq_ctrl.sv - sequencing controller for the shared div/sqrt iteration datapath
//
// Accepts FP and integer divide/sqrt start requests, loads the preprocessed
// iteration count, enables one recurrence step per cycle, stops on count
// exhaustion or an exact (zero-residual) result, and holds done until M accepts.
//
// Ports:
//   clk           clock
//   reset         asynchronous active-low reset
//   FDivStartE    FP div/sqrt issue request
//   IDivStartE    integer div/rem issue request
//   SpecialCaseE  result needs no iterations
//   CyclesE       iteration count, valid with the start request
//   WZeroE        residual exactly zero (early termination)
//   StallE        E-stage stall (only delays the start)
//   StallM        M-stage stall (extends DONE)
//   FlushE        E-stage flush
//   IFDivStartE   one-cycle load pulse to the datapath
//   DivStepE      iteration enable
//   FDivBusyE     unit occupied, stalls the pipeline
//   FDivDoneE     result ready for M
//   StepCntE      remaining iteration count

module fdivsqrt_seq_ctrl #(
  parameter int CNTW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FDivStartE,
  input  logic            IDivStartE,
  input  logic            SpecialCaseE,
  input  logic [CNTW-1:0] CyclesE,
  input  logic            WZeroE,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            FlushE,
  output logic            IFDivStartE,
  output logic            DivStepE,
  output logic            FDivBusyE,
  output logic            FDivDoneE,
  output logic [CNTW-1:0] StepCntE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] step_cnt;
  logic            step_q;
  logic            done_q;
  logic            start;
  logic            last_step;
  logic [CNTW-1:0] cnt_dec;

  // Gated with reset so the load pulse and busy also drop while reset is held.
  assign start = (FDivStartE | IDivStartE) & ~StallE & ~FlushE & (state == IDLE) & reset;

  // Saturating decrement: an underflow here would mean a broken iteration count.
  assign cnt_dec   = (step_cnt == '0) ? '0 : step_cnt - CNTW'(1);
  assign last_step = WZeroE | (step_cnt == CNTW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (SpecialCaseE || (CyclesE == '0)) begin
              state    <= DONE;
              step_cnt <= '0;
              done_q   <= 1'b1;
            end else begin
              state    <= BUSY;
              step_cnt <= CyclesE;
              step_q   <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (FlushE) begin
            // Flush wins even over a simultaneous termination: no DONE is produced.
            state    <= IDLE;
            step_cnt <= '0;
            step_q   <= 1'b0;
          end else if (last_step) begin
            state    <= DONE;
            step_cnt <= cnt_dec;
            step_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            step_cnt <= cnt_dec;
          end
        end
        DONE: begin
          if (FlushE || !StallM) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          step_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign IFDivStartE = start;
  assign DivStepE    = step_q;
  assign FDivDoneE   = done_q;
  assign StepCntE    = step_cnt;
  assign FDivBusyE   = step_q | start | (done_q & StallM);

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// tb/tb_fdivsqrt_seq_ctrl.sv - self-checking bench for fdivsqrt_seq_ctrl
module tb_fdivsqrt_seq_ctrl;

  localparam int CNTW = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            FDivStartE = 1'b0;
  logic            IDivStartE = 1'b0;
  logic            SpecialCaseE = 1'b0;
  logic [CNTW-1:0] CyclesE = '0;
  logic            WZeroE = 1'b0;
  logic            StallE = 1'b0;
  logic            StallM = 1'b0;
  logic            FlushE = 1'b0;
  logic            IFDivStartE;
  logic            DivStepE;
  logic            FDivBusyE;
  logic            FDivDoneE;
  logic [CNTW-1:0] StepCntE;

  fdivsqrt_seq_ctrl #(.CNTW(CNTW)) dut (
    .clk          (clk),
    .reset        (reset),
    .FDivStartE   (FDivStartE),
    .IDivStartE   (IDivStartE),
    .SpecialCaseE (SpecialCaseE),
    .CyclesE      (CyclesE),
    .WZeroE       (WZeroE),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushE       (FlushE),
    .IFDivStartE  (IFDivStartE),
    .DivStepE     (DivStepE),
    .FDivBusyE    (FDivBusyE),
    .FDivDoneE    (FDivDoneE),
    .StepCntE     (StepCntE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an operation is described by its length n and the number
  // of iterations already performed k; hold is the count visible outside BUSY.
  int ph = 0;   // 0 idle, 1 iterating, 2 result waiting for M
  int n = 0;
  int k = 0;
  int hold = 0;

  function automatic bit m_start();
    return reset && (FDivStartE || IDivStartE) && !StallE && !FlushE && (ph == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph   <= 0;
      hold <= 0;
    end else begin
      case (ph)
        0: if (m_start()) begin
          if (SpecialCaseE || (int'(CyclesE) == 0)) begin
            ph   <= 2;
            hold <= 0;
          end else begin
            ph <= 1;
            n  <= int'(CyclesE);
            k  <= 0;
          end
        end
        1: if (FlushE) begin
          ph   <= 0;
          hold <= 0;
        end else begin
          k <= k + 1;
          if (WZeroE || (k + 1 == n)) begin
            ph   <= 2;
            hold <= n - k - 1;
          end
        end
        2: if (FlushE || !StallM) ph <= 0;
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic s;
    s = m_start();
    chk("m_IFDivStartE", 32'(IFDivStartE), 32'(s));
    chk("m_DivStepE", 32'(DivStepE), 32'(ph == 1));
    chk("m_FDivDoneE", 32'(FDivDoneE), 32'(ph == 2));
    chk("m_FDivBusyE", 32'(FDivBusyE), 32'((ph == 1) || s || ((ph == 2) && StallM)));
    chk("m_StepCntE", 32'(StepCntE), (ph == 1) ? 32'(n - k) : 32'(hold));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    FDivStartE = 0; IDivStartE = 0; SpecialCaseE = 0; CyclesE = '0;
    WZeroE = 0; StallE = 0; StallM = 0; FlushE = 0;
  endtask

  initial begin
    #1 reset = 1'b0;
    nxt(); nxt();
    #2;
    chk("rst_start", 32'(IFDivStartE), 0);
    chk("rst_step", 32'(DivStepE), 0);
    chk("rst_done", 32'(FDivDoneE), 0);
    chk("rst_busy", 32'(FDivBusyE), 0);
    chk("rst_cnt", 32'(StepCntE), 0);
    nxt();
    reset = 1'b1;
    nxt();

    // FP divide, N=5, no stalls
    for (int c = 0; c <= 7; c++) begin
      FDivStartE = (c == 0); CyclesE = 7'd5;
      #2;
      chk("t1_start", 32'(IFDivStartE), 32'(c == 0));
      chk("t1_step", 32'(DivStepE), 32'(c >= 1 && c <= 5));
      if (c >= 1 && c <= 5) chk("t1_cnt", 32'(StepCntE), 32'(6 - c));
      chk("t1_done", 32'(FDivDoneE), 32'(c == 6));
      chk("t1_busy", 32'(FDivBusyE), 32'(c <= 5));
      nxt();
    end
    quiet();

    // Early termination, N=20, WZeroE in BUSY cycle 3
    for (int c = 0; c <= 5; c++) begin
      IDivStartE = (c == 0); CyclesE = 7'd20; WZeroE = (c == 3);
      #2;
      if (c == 3) chk("t2_cnt3", 32'(StepCntE), 18);
      if (c == 4) begin
        chk("t2_done4", 32'(FDivDoneE), 1);
        chk("t2_cnt4", 32'(StepCntE), 17);
      end
      if (c == 5) chk("t2_idle5", 32'(FDivDoneE), 0);
      nxt();
    end
    quiet();

    // Special case, then CyclesE = 0
    for (int sc = 0; sc < 2; sc++) begin
      for (int c = 0; c <= 2; c++) begin
        FDivStartE = (c == 0);
        SpecialCaseE = (sc == 0) && (c == 0);
        CyclesE = (sc == 0) ? 7'd9 : 7'd0;
        #2;
        chk("t3_step", 32'(DivStepE), 0);
        chk("t3_done", 32'(FDivDoneE), 32'(c == 1));
        if (c == 0) chk("t3_busy0", 32'(FDivBusyE), 1);
        if (c == 1) chk("t3_cnt1", 32'(StepCntE), 0);
        nxt();
      end
    end
    quiet();

    // DONE held by StallM, request during DONE ignored
    for (int c = 0; c <= 8; c++) begin
      FDivStartE = (c == 0) || (c == 4); CyclesE = 7'd2;
      StallM = (c >= 3 && c <= 5);
      #2;
      chk("t4_done", 32'(FDivDoneE), 32'(c >= 3 && c <= 6));
      chk("t4_busy", 32'(FDivBusyE), 32'(c <= 5));
      if (c == 4) chk("t4_ignored", 32'(IFDivStartE), 0);
      if (c == 7) chk("t4_step7", 32'(DivStepE), 0);
      nxt();
    end
    quiet();

    // Flush at BUSY cycle 2 of N=8
    for (int c = 0; c <= 5; c++) begin
      FDivStartE = (c == 0); CyclesE = 7'd8; FlushE = (c == 2);
      #2;
      chk("t5_done", 32'(FDivDoneE), 0);
      if (c == 2) chk("t5_cnt2", 32'(StepCntE), 7);
      if (c == 3) begin
        chk("t5_step3", 32'(DivStepE), 0);
        chk("t5_cnt3", 32'(StepCntE), 0);
      end
      nxt();
    end
    quiet();

    // Asynchronous reset in the middle of BUSY
    FDivStartE = 1; CyclesE = 7'd10;
    nxt();
    FDivStartE = 0;
    nxt();
    #2;
    chk("t6_pre_step", 32'(DivStepE), 1);
    reset = 1'b0;
    #1;
    chk("t6_step", 32'(DivStepE), 0);
    chk("t6_busy", 32'(FDivBusyE), 0);
    chk("t6_done", 32'(FDivDoneE), 0);
    chk("t6_cnt", 32'(StepCntE), 0);
    nxt(); nxt();
    reset = 1'b1;
    nxt();
    for (int c = 0; c <= 5; c++) begin
      FDivStartE = (c == 0); CyclesE = 7'd3;
      #2;
      chk("t7_step", 32'(DivStepE), 32'(c >= 1 && c <= 3));
      chk("t7_done", 32'(FDivDoneE), 32'(c == 4));
      nxt();
    end
    quiet();

    // Randomized traffic checked by the model on every cycle
    for (int i = 0; i < 3000; i++) begin
      FDivStartE   = ($urandom % 3) == 0;
      IDivStartE   = ($urandom % 5) == 0;
      SpecialCaseE = ($urandom % 8) == 0;
      CyclesE      = CNTW'($urandom % 13);
      WZeroE       = ($urandom % 10) == 0;
      StallE       = ($urandom % 4) == 0;
      StallM       = ($urandom % 3) == 0;
      FlushE       = ($urandom % 20) == 0;
      if (!reset) begin
        reset = 1'b1;
      end else if (($urandom % 150) == 0) begin
        #2;
        reset = 1'b0;
      end
      nxt();
    end
    quiet();
    reset = 1'b1;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
